overdrive_multi: RTL and testbench
==================================

Name: overdrive_multi

Overview:
- Parametrised next-generation overdrive stage for the pedal-board audio path. Processes one frame of CHANNELS signed samples per START.
- Applies a fixed-point gain, then one of three shaping modes: bypass, hard clip or soft-knee clip. Signals completion with a one-cycle DONE pulse.
- Uses one shared multiplier, time-multiplexed across channels in a 2-stage pipeline. Sits between the ADC frame buffer and the next effect in the chain.

Parameters:
- DATA_W, 16, sample width (signed two's complement)
- CHANNELS, 2, samples per frame, >=1
- GAIN_W, 8, gain word width (unsigned fixed point)
- GAIN_FRAC, 4, fractional bits of gain (0x10 = 1.0 with defaults)
- KNEE, 16'sh4000, soft-clip knee magnitude, 0 < KNEE <= 2^(DATA_W-1)-1

Ports:
- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- START  in  1  request to process the current input_frame
- MODE  in  2  0 bypass, 1 hard clip, 2 soft clip, 3 reserved (acts as hard clip)
- GAIN  in  GAIN_W  unsigned gain, GAIN_FRAC fractional bits
- input_frame  in  CHANNELS*DATA_W  ch k at bits [k*DATA_W +: DATA_W]
- output_frame  out  CHANNELS*DATA_W  processed frame, same packing
- BUSY  out  1  high while a frame is in flight
- DONE  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, RESET_N=0): state IDLE, output_frame=0, DONE=0, BUSY=0, shadow and pipeline registers cleared. Reset mid-frame abandons the frame; no DONE follows.
- FSM has three states: IDLE, RUN, FINISH.
- IDLE: START=1 at edge E0 latches input_frame, GAIN and MODE. The FSM moves to RUN with BUSY=1. Later changes to inputs do not affect the frame.
- RUN pipeline: stage 1 takes ch idx, forms product = sample * {1'b0,GAIN}, signed, width DATA_W+GAIN_W+1. It then computes s = product >>> GAIN_FRAC (arithmetic shift, truncates toward -inf). Stage 2 shapes s and writes it into the shadow frame at idx-1.
- RUN lasts CHANNELS+1 cycles, with the channel counter running 0..CHANNELS. The FSM then goes to FINISH.
- FINISH (1 cycle): output_frame <= shadow frame, all channels in one atomic update. DONE=1 and BUSY=0 for this cycle. Next state IDLE.
- Latency: DONE and the output_frame update occur at edge E0+CHANNELS+2. output_frame holds its value between frames.
- START while BUSY or in FINISH is ignored (no queueing). If START is still high in the cycle after FINISH, the next frame starts, giving back-to-back throughput of one frame per CHANNELS+3 cycles.
- Shaping (MAX=2^(DATA_W-1)-1, MIN=-2^(DATA_W-1)):
  - bypass: output equals the latched sample; gain ignored.
  - hard: y = sat(s).
  - soft: for s>KNEE, y=sat(KNEE+((s-KNEE)>>>2)); for s<-KNEE, y=sat(-KNEE+((s+KNEE)>>>2)); otherwise y=s.
  - sat() clamps to [MIN, MAX]. Intermediate arithmetic is at full width; no wrap is permitted.
- GAIN=0 in hard/soft mode gives an all-zero output frame.

Decomposition:
- Package overdrive_pkg holds:
  - the od_mode_e enum (BYPASS, HARD, SOFT, RSVD);
  - the od_state_e enum (IDLE, RUN, FINISH);
  - a saturate function parametrised by input width and DATA_W.
- Sub-module od_shaper: purely combinational. Takes s, MODE and the raw sample and returns the DATA_W result. It is instantiated once as stage 2.

Test Plan (defaults; gain 0x30=3.0, 0x20=2.0, 0x18=1.5):
- Hard, gain 3.0, ch0=0x2000, ch1=0xE000 -> 0x6000, 0xA000. DONE high exactly one cycle, 4 edges after START accept; BUSY high the 3 cycles before.
- Hard saturation, gain 3.0, ch0=0x4000, ch1=0x8000 -> 0x7FFF, 0x8000. Also gain 1.5, ch0=0x0003, ch1=0xFFFD -> 0x0004, 0xFFFB (floor rounding).
- Soft, gain 2.0, ch0=0x3000, ch1=0xD000 -> 0x4800, 0xB800. Also gain 0xFF, ch0=0x7FFF -> 0x7FFF; ch0=0x1000 at gain 2.0 -> 0x2000 (below knee).
- Bypass with GAIN=0, ch0=0x1234, ch1=0x8001 -> unchanged. MODE=3 -> identical to hard-clip results.
- Protocol:
  - START pulsed again during BUSY -> ignored, one DONE only.
  - GAIN/MODE changed mid-frame -> result uses the latched values.
  - START held high -> DONE every 5 cycles.
- RESET_N low during RUN -> outputs 0 immediately and no DONE. After release, a new frame completes with correct values.

Source files
------------

// File: rtl/overdrive_pkg.sv
// Shared types and helpers for the multi-channel overdrive stage.
package overdrive_pkg;

   typedef enum logic [1:0] {
      BYPASS = 2'd0,
      HARD   = 2'd1,
      SOFT   = 2'd2,
      RSVD   = 2'd3
   } od_mode_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } od_state_e;

   localparam int unsigned SAT_W = 64;

   // Clamp a sign-extended value of in_w significant bits to the signed range of dw bits.
   function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                   input int unsigned in_w,
                                                   input int unsigned dw);
      logic signed [SAT_W-1:0] mx;
      logic signed [SAT_W-1:0] mn;
      mx = (SAT_W'(64'sd1) <<< (dw - 1)) - SAT_W'(64'sd1);
      mn = -mx - SAT_W'(64'sd1);
      if (in_w <= dw) begin
         sat = x;
      end else if (x > mx) begin
         sat = mx;
      end else if (x < mn) begin
         sat = mn;
      end else begin
         sat = x;
      end
   endfunction

endpackage

// File: rtl/overdrive_multi_if.sv
// Frame request/response bundle between the frame buffer and the overdrive stage.
interface overdrive_multi_if #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned GAIN_W   = 8
);
   logic                         START;
   logic [1:0]                   MODE;
   logic [GAIN_W-1:0]            GAIN;
   logic [CHANNELS*DATA_W-1:0]   input_frame;
   logic [CHANNELS*DATA_W-1:0]   output_frame;
   logic                         BUSY;
   logic                         DONE;

   modport master (
      output START, MODE, GAIN, input_frame,
      input  output_frame, BUSY, DONE
   );

   modport slave (
      input  START, MODE, GAIN, input_frame,
      output output_frame, BUSY, DONE
   );
endinterface

// File: rtl/od_shaper.sv
// Combinational shaping of one gained sample: bypass, hard clip or soft-knee clip.
module od_shaper
   import overdrive_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned S_W    = 25,
   parameter int          KNEE   = 'h4000
) (
   input  logic signed [S_W-1:0]    s,
   input  od_mode_e                 mode,
   input  logic signed [DATA_W-1:0] raw,
   output logic signed [DATA_W-1:0] y_c
);
   localparam int unsigned XW = S_W + 2;
   localparam logic signed [XW-1:0] KX = XW'(KNEE);

   logic signed [XW-1:0] sx;
   logic signed [XW-1:0] knee_c;

   assign sx = XW'(s);

   // Compress beyond the knee at a 1/4 slope; headroom in XW keeps this wrap-free.
   always_comb begin
      knee_c = sx;
      if (sx > KX) begin
         knee_c = KX + ((sx - KX) >>> 2);
      end else if (sx < -KX) begin
         knee_c = -KX + ((sx + KX) >>> 2);
      end
   end

   always_comb begin
      y_c = raw;
      case (mode)
         BYPASS:  y_c = raw;
         SOFT:    y_c = DATA_W'(sat(SAT_W'(knee_c), XW, DATA_W));
         default: y_c = DATA_W'(sat(SAT_W'(sx), XW, DATA_W));
      endcase
   end
endmodule

// File: rtl/overdrive_multi.sv
// Frame-based overdrive: one shared multiplier walks the channels through a 2-stage pipeline.
module overdrive_multi
   import overdrive_pkg::*;
#(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned CHANNELS  = 2,
   parameter int unsigned GAIN_W    = 8,
   parameter int unsigned GAIN_FRAC = 4,
   parameter int          KNEE      = 'h4000
) (
   input logic              CLK,
   input logic              RESET_N,
   overdrive_multi_if.slave bus
);
   localparam int unsigned PROD_W = DATA_W + GAIN_W + 1;
   localparam int unsigned CNT_W  = $clog2(CHANNELS + 1);
   localparam int unsigned IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   od_state_e                  state_q, state_d;
   logic [CNT_W-1:0]           idx_q;
   logic signed [DATA_W-1:0]   in_q     [CHANNELS];
   logic signed [DATA_W-1:0]   shadow_q [CHANNELS];
   logic [GAIN_W-1:0]          gain_q;
   od_mode_e                   mode_q;
   logic signed [PROD_W-1:0]   s_q;
   logic signed [DATA_W-1:0]   raw_q;
   logic [CHANNELS*DATA_W-1:0] out_q;
   logic                       busy_q;
   logic                       done_q;

   logic [IDX_W-1:0]           rd_sel_c;
   logic [IDX_W-1:0]           wr_sel_c;
   logic signed [DATA_W-1:0]   sample_c;
   logic signed [PROD_W-1:0]   prod_c;
   logic signed [PROD_W-1:0]   s_c;
   logic signed [DATA_W-1:0]   y_c;

   assign bus.output_frame = out_q;
   assign bus.BUSY         = busy_q;
   assign bus.DONE         = done_q;

   // Stage 1: gain multiply on the channel selected by idx; idx==CHANNELS only drains stage 2.
   assign rd_sel_c = (idx_q < CNT_W'(CHANNELS)) ? IDX_W'(idx_q) : '0;
   assign wr_sel_c = IDX_W'(idx_q - CNT_W'(1));
   assign sample_c = in_q[rd_sel_c];
   assign prod_c   = PROD_W'(sample_c) * PROD_W'($signed({1'b0, gain_q}));
   assign s_c      = prod_c >>> GAIN_FRAC;

   od_shaper #(
      .DATA_W (DATA_W),
      .S_W    (PROD_W),
      .KNEE   (KNEE)
   ) u_shaper (
      .s    (s_q),
      .mode (mode_q),
      .raw  (raw_q),
      .y_c  (y_c)
   );

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.START) state_d = RUN;
         RUN:     if (idx_q == CNT_W'(CHANNELS)) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         idx_q  <= '0;
         gain_q <= '0;
         mode_q <= BYPASS;
         s_q    <= '0;
         raw_q  <= '0;
         out_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            in_q[k]     <= '0;
            shadow_q[k] <= '0;
         end
      end else begin
         busy_q <= (state_q == RUN);
         done_q <= (state_q == FINISH);
         case (state_q)
            IDLE: begin
               if (bus.START) begin
                  idx_q  <= '0;
                  gain_q <= bus.GAIN;
                  mode_q <= od_mode_e'(bus.MODE);
                  for (int k = 0; k < CHANNELS; k++) begin
                     in_q[k] <= bus.input_frame[k*DATA_W +: DATA_W];
                  end
               end
            end
            RUN: begin
               idx_q <= idx_q + CNT_W'(1);
               if (idx_q < CNT_W'(CHANNELS)) begin
                  s_q   <= s_c;
                  raw_q <= sample_c;
               end
               if (idx_q != '0) begin
                  shadow_q[wr_sel_c] <= y_c;
               end
            end
            FINISH: begin
               for (int k = 0; k < CHANNELS; k++) begin
                  out_q[k*DATA_W +: DATA_W] <= shadow_q[k];
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_overdrive_multi.sv
// Directed self-checking bench for overdrive_multi at default parameters.
module tb_overdrive_multi;
   logic CLK;
   logic RESET_N;
   int   n_checks;
   int   n_errs;

   overdrive_multi_if #(.DATA_W(16), .CHANNELS(2), .GAIN_W(8)) bus ();

   overdrive_multi #(
      .DATA_W    (16),
      .CHANNELS  (2),
      .GAIN_W    (8),
      .GAIN_FRAC (4),
      .KNEE      ('h4000)
   ) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // One frame with cycle-accurate BUSY/DONE checks; inputs are scrambled after accept.
   task automatic do_frame(input string tag, input logic [1:0] m, input logic [7:0] g,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] ea, input logic [15:0] eb, input bit poke);
      int ndone;
      bus.MODE        = m;
      bus.GAIN        = g;
      bus.input_frame = {b, a};
      bus.START       = 1'b1;
      @(posedge CLK);
      #1;
      bus.START       = 1'b0;
      bus.MODE        = ~m;
      bus.GAIN        = ~g;
      bus.input_frame = ~{b, a};
      for (int i = 1; i <= 4; i++) begin
         @(posedge CLK);
         #1;
         chk($sformatf("%s busy@%0d", tag, i), 64'(bus.BUSY), 64'(i < 4));
         chk($sformatf("%s done@%0d", tag, i), 64'(bus.DONE), 64'(i == 4));
         if (poke && i == 1) bus.START = 1'b1;
         if (poke && i == 2) bus.START = 1'b0;
      end
      chk({tag, " out"}, 64'(bus.output_frame), 64'({eb, ea}));
      @(posedge CLK);
      #1;
      chk({tag, " done_end"}, 64'(bus.DONE), 64'd0);
      if (poke) begin
         ndone = 0;
         for (int i = 0; i < 8; i++) begin
            @(posedge CLK);
            #1;
            if (bus.DONE) ndone++;
         end
         chk({tag, " extra_done"}, 64'(ndone), 64'd0);
      end
   endtask

   initial begin
      int c0, c1, cyc, ndone;
      n_checks        = 0;
      n_errs          = 0;
      RESET_N         = 1'b0;
      bus.START       = 1'b0;
      bus.MODE        = 2'd0;
      bus.GAIN        = 8'd0;
      bus.input_frame = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst out", 64'(bus.output_frame), 64'd0);
      chk("rst busy", 64'(bus.BUSY), 64'd0);
      chk("rst done", 64'(bus.DONE), 64'd0);
      @(negedge CLK);
      RESET_N = 1'b1;
      @(posedge CLK);
      #1;

      do_frame("hard3",    2'd1, 8'h30, 16'h2000, 16'hE000, 16'h6000, 16'hA000, 1'b0);
      do_frame("hardsat",  2'd1, 8'h30, 16'h4000, 16'h8000, 16'h7FFF, 16'h8000, 1'b0);
      do_frame("hard1p5",  2'd1, 8'h18, 16'h0003, 16'hFFFD, 16'h0004, 16'hFFFB, 1'b0);
      do_frame("soft2",    2'd2, 8'h20, 16'h3000, 16'hD000, 16'h4800, 16'hB800, 1'b0);
      do_frame("softmax",  2'd2, 8'hFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 1'b0);
      do_frame("softlow",  2'd2, 8'h20, 16'h1000, 16'hF000, 16'h2000, 16'hE000, 1'b0);
      do_frame("bypass",   2'd0, 8'h00, 16'h1234, 16'h8001, 16'h1234, 16'h8001, 1'b0);
      do_frame("gain0",    2'd1, 8'h00, 16'h1234, 16'h8001, 16'h0000, 16'h0000, 1'b0);
      do_frame("rsvd",     2'd3, 8'h30, 16'h4000, 16'hE000, 16'h7FFF, 16'hA000, 1'b0);
      do_frame("poke",     2'd1, 8'h30, 16'h2000, 16'hE000, 16'h6000, 16'hA000, 1'b1);

      // START held high: back-to-back frames, DONE every CHANNELS+3 cycles.
      bus.MODE        = 2'd1;
      bus.GAIN        = 8'h20;
      bus.input_frame = {16'hF000, 16'h0100};
      bus.START       = 1'b1;
      c0 = -1;
      c1 = -1;
      cyc = 0;
      while (c1 < 0 && cyc < 30) begin
         @(posedge CLK);
         #1;
         cyc++;
         if (bus.DONE) begin
            if (c0 < 0) c0 = cyc;
            else        c1 = cyc;
         end
      end
      bus.START = 1'b0;
      chk("held seen", 64'(c1 >= 0), 64'd1);
      chk("held period", 64'(c1 - c0), 64'd5);
      chk("held out", 64'(bus.output_frame), 64'({16'hE000, 16'h0200}));
      repeat (6) @(posedge CLK);
      #1;

      // Reset during RUN abandons the frame.
      bus.MODE        = 2'd1;
      bus.GAIN        = 8'h30;
      bus.input_frame = {16'h0010, 16'h0020};
      bus.START       = 1'b1;
      @(posedge CLK);
      #1;
      bus.START = 1'b0;
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      RESET_N = 1'b0;
      #1;
      chk("midrst out", 64'(bus.output_frame), 64'd0);
      chk("midrst busy", 64'(bus.BUSY), 64'd0);
      chk("midrst done", 64'(bus.DONE), 64'd0);
      @(negedge CLK);
      RESET_N = 1'b1;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge CLK);
         #1;
         if (bus.DONE) ndone++;
      end
      chk("midrst nodone", 64'(ndone), 64'd0);
      chk("midrst hold", 64'(bus.output_frame), 64'd0);
      do_frame("postrst", 2'd1, 8'h30, 16'h2000, 16'hE000, 16'h6000, 16'hA000, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end
endmodule
